// File: rtl/mem_arbiter.sv
// Grants one of NUM_CH memory requesters to the controller and returns the result to that channel.
// Latency: grant registered the edge after req_valid is sampled; response same cycle as mc_ready.
// Backpressure: requesters hold req_valid until resp_ready; rdy_in=0 freezes all state.
module mem_arbiter #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_MODE = 0,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b001,
    localparam int ID_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [3*NUM_CH-1:0]      req_len,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [DATA_W*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]        resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     mc_valid,
    output logic                     mc_wr,
    output logic [ADDR_W-1:0]        mc_addr,
    output logic [2:0]               mc_len,
    output logic [DATA_W-1:0]        mc_data,
    output logic                     mc_abort,
    input  logic                     mc_ready,
    input  logic [DATA_W-1:0]        mc_res,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant;
    logic                w_kill;
    logic                w_done;
    logic [ID_W-1:0]     w_win;
    int                  w_off;
    int                  w_best;
    logic                w_sel_wr;
    logic [2:0]          w_sel_len;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_mc_valid;
    logic                r_mc_wr;
    logic [ADDR_W-1:0]   r_mc_addr;
    logic [2:0]          r_mc_len;
    logic [DATA_W-1:0]   r_mc_data;
    logic                r_mc_abort;

    assign w_kill = (r_state == S_BUSY) && flush && !r_mc_wr && FLUSH_MASK[r_grant_id];
    assign w_done = (r_state == S_BUSY) && mc_ready && !w_kill;

    // Winner = valid channel with the smallest distance from the scan start
    // (channel 0 in fixed mode, the one after the last completed owner in RR mode).
    always_comb begin
        w_win  = '0;
        w_off  = 0;
        w_best = NUM_CH;
        for (int j = 0; j < NUM_CH; j++) begin
            w_off = (RR_MODE != 0) ? (j + 2 * NUM_CH - 1 - int'(r_last)) % NUM_CH : j;
            if (req_valid[j] && (w_off < w_best)) begin
                w_best = w_off;
                w_win  = ID_W'(j);
            end
        end
    end

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_len  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == ID_W'(i)) begin
                w_sel_wr   = req_wr[i];
                w_sel_len  = req_len[3*i +: 3];
                w_sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                w_sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && (|req_valid)) begin
                    w_state_nxt = S_BUSY;
                    w_grant     = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_kill || mc_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mc_valid <= 1'b0;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_len   <= '0;
            r_mc_data  <= '0;
            r_mc_abort <= 1'b0;
            r_grant_id <= '0;
            r_last     <= ID_W'(NUM_CH - 1);
        end else if (rdy_in) begin
            r_mc_abort <= w_kill;
            if (w_grant) begin
                r_mc_valid <= 1'b1;
                r_mc_wr    <= w_sel_wr;
                r_mc_len   <= w_sel_len;
                r_mc_addr  <= w_sel_addr;
                r_mc_data  <= w_sel_data;
                r_grant_id <= w_win;
            end else if (w_state_nxt == S_IDLE) begin
                r_mc_valid <= 1'b0;
            end
            if (w_done) begin
                r_last <= r_grant_id;
            end
        end
    end

    always_comb begin
        resp_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            resp_ready[i] = w_done && rdy_in && !rst_in && (r_grant_id == ID_W'(i));
        end
    end

    assign resp_data = mc_res;
    assign mc_valid  = r_mc_valid;
    assign mc_wr     = r_mc_wr;
    assign mc_addr   = r_mc_addr;
    assign mc_len    = r_mc_len;
    assign mc_data   = r_mc_data;
    assign mc_abort  = r_mc_abort;
    assign busy      = (r_state == S_BUSY);
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random requesters and controller drive a fixed-priority and a round-robin arbiter;
// expected grants, responses and abort pulses are queued and matched by per-instance monitors.
module tb_mem_arbiter;

    localparam int NCH    = 3;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int NCYC   = 3000;
    localparam int NDRAIN = 24;

    typedef struct {
        int          stamp;
        int          ch;
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic           clk   = 1'b0;
    int             cyc   = 0;
    int             total = 0;
    int             bad   = 0;
    logic [NCH-1:0] fmask = 3'b001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input int g);
        total++;
        bad++;
        $display("FAIL %s dut%0d cyc=%0d got=event want=none", nm, g, cyc);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        logic               rst, rdy, fl, mrdy;
        logic [NCH-1:0]     rv, rw;
        logic [3*NCH-1:0]   rl;
        logic [AW*NCH-1:0]  ra;
        logic [DW*NCH-1:0]  rd;
        logic [DW-1:0]      mres;
        logic [NCH-1:0]     resp;
        logic [DW-1:0]      rdat;
        logic               mv, mw, mab, bsy;
        logic [AW-1:0]      ma;
        logic [2:0]         ml;
        logic [DW-1:0]      md;
        logic [1:0]         gid;
        ev_t                q_grant[$];
        ev_t                q_resp[$];
        int                 q_end[$];
        int                 q_arise[$];
        int                 q_afall[$];
        bit                 fin = 1'b0;

        mem_arbiter #(
            .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(g), .FLUSH_MASK(3'b001)
        ) dut (
            .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(fl),
            .req_valid(rv), .req_wr(rw), .req_len(rl), .req_addr(ra), .req_data(rd),
            .resp_ready(resp), .resp_data(rdat),
            .mc_valid(mv), .mc_wr(mw), .mc_addr(ma), .mc_len(ml), .mc_data(md),
            .mc_abort(mab), .mc_ready(mrdy), .mc_res(mres),
            .busy(bsy), .grant_id(gid)
        );

        // Requesters, controller and reference model.
        initial begin : drv
            ev_t pend [NCH];
            bit  pv   [NCH];
            bit  m_busy, m_abort, quiet;
            int  m_owner, m_last, c, w;
            ev_t e;
            rst = 1'b1; rdy = 1'b1; fl = 1'b0; mrdy = 1'b0; mres = '0;
            rv = '0; rw = '0; rl = '0; ra = '0; rd = '0;
            for (int ch = 0; ch < NCH; ch++) pv[ch] = 1'b0;
            m_busy = 1'b0; m_abort = 1'b0; m_owner = 0; m_last = NCH - 1;
            repeat (3) @(posedge clk);
            for (int n = 0; n < NCYC + NDRAIN; n++) begin
                @(posedge clk);
                #1;
                c     = cyc;
                quiet = (n >= NCYC);
                for (int ch = 0; ch < NCH; ch++) begin
                    if (!pv[ch] && !quiet && $urandom_range(0, 3) == 0) begin
                        pv[ch]        = 1'b1;
                        pend[ch].ch   = ch;
                        pend[ch].wr   = 1'($urandom_range(0, 1));
                        pend[ch].len  = 3'($urandom_range(0, 7));
                        pend[ch].addr = $urandom;
                        pend[ch].data = $urandom;
                    end
                    rv[ch]            = pv[ch];
                    rw[ch]            = pend[ch].wr;
                    rl[3*ch +: 3]     = pend[ch].len;
                    ra[AW*ch +: AW]   = pend[ch].addr;
                    rd[DW*ch +: DW]   = pend[ch].data;
                end
                rst  = !quiet && ($urandom_range(0, 149) == 0);
                rdy  = quiet || ($urandom_range(0, 4) != 0);
                fl   = !quiet && ($urandom_range(0, 7) == 0);
                mrdy = quiet || ($urandom_range(0, 2) == 0);
                mres = $urandom;

                if (rst) begin
                    if (m_busy) q_end.push_back(c + 1);
                    if (m_abort) q_afall.push_back(c + 1);
                    m_busy = 1'b0; m_abort = 1'b0; m_last = NCH - 1;
                end else if (rdy) begin
                    if (m_abort) begin
                        q_afall.push_back(c + 1);
                        m_abort = 1'b0;
                    end
                    if (m_busy) begin
                        if (fl && !pend[m_owner].wr && fmask[m_owner]) begin
                            q_arise.push_back(c + 1);
                            q_end.push_back(c + 1);
                            m_abort = 1'b1;
                            m_busy  = 1'b0;
                        end else if (mrdy) begin
                            e = pend[m_owner];
                            e.stamp = c;
                            e.data  = mres;
                            q_resp.push_back(e);
                            q_end.push_back(c + 1);
                            m_busy = 1'b0;
                            m_last = m_owner;
                            pv[m_owner] = 1'b0;
                        end
                    end else if (!fl) begin
                        w = -1;
                        for (int k = 1; k <= NCH; k++) begin
                            int ch;
                            ch = (g == 1) ? (m_last + k) % NCH : k - 1;
                            if (w < 0 && pv[ch]) w = ch;
                        end
                        if (w >= 0) begin
                            e = pend[w];
                            e.stamp = c + 1;
                            q_grant.push_back(e);
                            m_busy  = 1'b1;
                            m_owner = w;
                        end
                    end
                end
            end
            repeat (3) @(negedge clk);
            chk("left_grant", g, q_grant.size(), 0);
            chk("left_resp",  g, q_resp.size(), 0);
            chk("left_end",   g, q_end.size(), 0);
            chk("left_arise", g, q_arise.size(), 0);
            chk("left_afall", g, q_afall.size(), 0);
            fin = 1'b1;
        end

        initial begin : mon
            bit  p_mv, p_ab, p_rst;
            ev_t cur, e;
            int  s;
            p_mv = 1'b0; p_ab = 1'b0; p_rst = 1'b0;
            cur = '{default: 0};
            forever begin
                @(negedge clk);
                if (cyc >= 2) begin
                    if (p_rst) begin
                        chk("rst_mc_valid", g, mv, 0);
                        chk("rst_mc_wr",    g, mw, 0);
                        chk("rst_mc_addr",  g, ma, 0);
                        chk("rst_mc_len",   g, ml, 0);
                        chk("rst_mc_data",  g, md, 0);
                        chk("rst_mc_abort", g, mab, 0);
                        chk("rst_busy",     g, bsy, 0);
                        chk("rst_grant_id", g, gid, 0);
                        chk("rst_resp",     g, resp, 0);
                    end
                    if (mv && !p_mv) begin
                        if (q_grant.size() == 0) unexp("grant", g);
                        else begin
                            e = q_grant.pop_front();
                            cur = e;
                            chk("grant_cycle", g, cyc, e.stamp);
                            chk("grant_id",    g, gid, e.ch);
                            chk("grant_wr",    g, mw, e.wr);
                            chk("grant_len",   g, ml, e.len);
                            chk("grant_addr",  g, ma, e.addr);
                            chk("grant_data",  g, md, e.data);
                            chk("grant_busy",  g, bsy, 1);
                        end
                    end else if (mv && p_mv) begin
                        chk("hold_addr", g, ma, cur.addr);
                        chk("hold_id",   g, gid, cur.ch);
                    end
                    if (!mv && p_mv) begin
                        if (q_end.size() == 0) unexp("end", g);
                        else begin
                            s = q_end.pop_front();
                            chk("end_cycle", g, cyc, s);
                            chk("end_busy",  g, bsy, 0);
                        end
                    end
                    if (resp != '0) begin
                        if (q_resp.size() == 0) unexp("resp", g);
                        else begin
                            e = q_resp.pop_front();
                            chk("resp_cycle",  g, cyc, e.stamp);
                            chk("resp_onehot", g, resp, 1 << e.ch);
                            chk("resp_data",   g, rdat, e.data);
                        end
                    end
                    if (mab && !p_ab) begin
                        if (q_arise.size() == 0) unexp("abort_rise", g);
                        else begin
                            s = q_arise.pop_front();
                            chk("abort_rise_cycle", g, cyc, s);
                        end
                    end
                    if (!mab && p_ab) begin
                        if (q_afall.size() == 0) unexp("abort_fall", g);
                        else begin
                            s = q_afall.pop_front();
                            chk("abort_fall_cycle", g, cyc, s);
                        end
                    end
                end
                p_mv  = mv;
                p_ab  = mab;
                p_rst = rst;
            end
        end
    end

    initial begin
        wait (u[0].fin && u[1].fin);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #((NCYC + NDRAIN + 100) * 10);
        total++;
        bad++;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
